// File: rtl/updown_chk_pkg.sv
// Shared types and default sizes for the up/down counter checker.
// The checker FSM states and the default count and error-counter widths.
package updown_chk_pkg;

   localparam int DEF_WIDTH     = 8;
   localparam int DEF_ERR_CNT_W = 8;

   typedef enum logic {
      ST_UNSYNC = 1'b0,
      ST_CHECK  = 1'b1
   } chk_state_t;

endpackage

// File: rtl/updown_ref_model.sv
// Reference model of the monitored counter: rst > load > up/down, modulo 2^WIDTH.
// Latency: controls sampled at edge k appear on model after edge k; no backpressure, en gates the update.
// Backpressure: none, this is a passive model register.
module updown_ref_model
   import updown_chk_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mon_rst,
   input  logic             mon_load,
   input  logic             mon_updown,
   input  logic [WIDTH-1:0] mon_data_in,
   output logic [WIDTH-1:0] model
);

   logic [WIDTH-1:0] model_nxt;

   always_comb begin
      model_nxt = model;
      if (mon_rst)
         model_nxt = '0;
      else if (mon_load)
         model_nxt = mon_data_in;
      else if (mon_updown)
         model_nxt = model + WIDTH'(1);
      else
         model_nxt = model - WIDTH'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         model <= '0;
      else if (en)
         model <= model_nxt;
   end

endmodule

// File: rtl/up_down_count_checker.sv
// Passive checker for the up/down counter; flags each cycle its count disagrees with a reference model.
// Latency: err/err_cnt update on the edge that samples the bad count; optional capture via CHK_ERR_CAPTURE_EN.
// Backpressure: none, never drives the counter.
module up_down_count_checker
   import updown_chk_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mon_rst,
   input  logic                 mon_load,
   input  logic                 mon_updown,
   input  logic [WIDTH-1:0]     mon_data_in,
   input  logic [WIDTH-1:0]     mon_count,
   output logic                 synced,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [WIDTH-1:0]     exp_count
`ifdef CHK_ERR_CAPTURE_EN
   ,
   output logic                 cap_valid,
   output logic [WIDTH-1:0]     cap_exp,
   output logic [WIDTH-1:0]     cap_act
`endif
);

   chk_state_t state, state_nxt;
   logic       model_en;
   logic       mismatch;

   // In UNSYNC the model only moves on an event that fully defines the count.
   assign model_en = (state == ST_CHECK) || mon_rst || mon_load;
   assign mismatch = (state == ST_CHECK) && (mon_count != exp_count);
   assign synced   = (state == ST_CHECK);

   updown_ref_model #(.WIDTH(WIDTH)) u_model (
      .clk         (clk),
      .rst         (rst),
      .en          (model_en),
      .mon_rst     (mon_rst),
      .mon_load    (mon_load),
      .mon_updown  (mon_updown),
      .mon_data_in (mon_data_in),
      .model       (exp_count)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_UNSYNC: if (mon_rst || mon_load) state_nxt = ST_CHECK;
         ST_CHECK:  state_nxt = ST_CHECK;
         default:   state_nxt = ST_UNSYNC;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_UNSYNC;
         err     <= 1'b0;
         err_cnt <= '0;
      end else begin
         state <= state_nxt;
         err   <= mismatch;
         if (mismatch && (err_cnt != {ERR_CNT_W{1'b1}}))
            err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
   end

`ifdef CHK_ERR_CAPTURE_EN
   // Only the first mismatch after rst is kept; it is usually the informative one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_valid <= 1'b0;
         cap_exp   <= '0;
         cap_act   <= '0;
      end else if (mismatch && !cap_valid) begin
         cap_valid <= 1'b1;
         cap_exp   <= exp_count;
         cap_act   <= mon_count;
      end
   end
`endif

endmodule

// File: tb/tb_up_down_count_checker.sv
// Directed bench for up_down_count_checker with a behavioural model compared every cycle.
module tb_up_down_count_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mon_rst = 1'b0;
   logic       mon_load = 1'b0;
   logic       mon_updown = 1'b1;
   logic [7:0] mon_data_in = 8'd0;
   logic [7:0] mon_count;
   logic       synced;
   logic       err;
   logic [1:0] err_cnt;
   logic [7:0] exp_count;
`ifdef CHK_ERR_CAPTURE_EN
   logic       cap_valid;
   logic [7:0] cap_exp;
   logic [7:0] cap_act;
`endif

   int n_cmp = 0;
   int n_fail = 0;

   // A correct counter driving mon_count, with an override for fault injection.
   logic [7:0] ctr = 8'd0;
   logic       force_en = 1'b0;
   logic [7:0] force_val = 8'd0;
   assign mon_count = force_en ? force_val : ctr;

   always #5 clk = ~clk;

   up_down_count_checker #(.WIDTH(8), .ERR_CNT_W(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .mon_rst     (mon_rst),
      .mon_load    (mon_load),
      .mon_updown  (mon_updown),
      .mon_data_in (mon_data_in),
      .mon_count   (mon_count),
      .synced      (synced),
      .err         (err),
      .err_cnt     (err_cnt),
      .exp_count   (exp_count)
`ifdef CHK_ERR_CAPTURE_EN
      ,
      .cap_valid   (cap_valid),
      .cap_exp     (cap_exp),
      .cap_act     (cap_act)
`endif
   );

   always @(posedge clk) begin
      if (mon_rst)         ctr <= 8'd0;
      else if (mon_load)   ctr <= mon_data_in;
      else if (mon_updown) ctr <= ctr + 8'd1;
      else                 ctr <= ctr - 8'd1;
   end

   // Behavioural expectation: integers, wrap by modulo, saturating count as a min().
   bit m_sync = 0;
   int m_exp = 0;
   bit m_err = 0;
   int m_cnt = 0;
   bit m_capv = 0;
   int m_cape = 0;
   int m_capa = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_sync = 0; m_exp = 0; m_err = 0; m_cnt = 0;
         m_capv = 0; m_cape = 0; m_capa = 0;
      end else begin
         m_err = m_sync && (int'(mon_count) != m_exp);
         if (m_err) begin
            m_cnt = (m_cnt + 1 > 3) ? 3 : m_cnt + 1;
            if (!m_capv) begin
               m_capv = 1; m_cape = m_exp; m_capa = int'(mon_count);
            end
         end
         if (mon_rst) begin
            m_exp = 0; m_sync = 1;
         end else if (mon_load) begin
            m_exp = int'(mon_data_in); m_sync = 1;
         end else if (m_sync) begin
            m_exp = (m_exp + (mon_updown ? 1 : 255)) % 256;
         end
      end
   end

   task automatic check(input string name, input int act, input int expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      check("synced", int'(synced), int'(m_sync));
      check("err", int'(err), int'(m_err));
      check("err_cnt", int'(err_cnt), m_cnt);
      check("exp_count", int'(exp_count), m_exp);
`ifdef CHK_ERR_CAPTURE_EN
      check("cap_valid", int'(cap_valid), int'(m_capv));
      check("cap_exp", int'(cap_exp), m_cape);
      check("cap_act", int'(cap_act), m_capa);
`endif
   end

   task automatic drive(input logic r, input logic l, input logic u, input logic [7:0] d);
      mon_rst = r; mon_load = l; mon_updown = u; mon_data_in = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      tick(); tick();
      check("rst_synced", int'(synced), 0);
      check("rst_err_cnt", int'(err_cnt), 0);
      check("rst_exp", int'(exp_count), 0);
      #2 rst = 1'b0;

      // 1. sync on mon_rst, then count up 10
      drive(1, 0, 1, 8'd0); tick();
      check("sync_after_mon_rst", int'(synced), 1);
      drive(0, 0, 1, 8'd0);
      repeat (10) tick();
      check("up10_exp", int'(exp_count), 10);
      check("up10_no_err", int'(err_cnt), 0);

      // 2. load and down-wrap
      drive(0, 1, 1, 8'd200); tick();
      check("load200", int'(exp_count), 200);
      drive(0, 1, 0, 8'd0); tick();
      drive(0, 0, 0, 8'd0); tick();
      check("down_wrap_255", int'(exp_count), 255);
      tick();
      check("down_254", int'(exp_count), 254);

      // 3. up-wrap
      drive(0, 1, 1, 8'd254); tick();
      drive(0, 0, 1, 8'd0); tick();
      check("upwrap_255", int'(exp_count), 255);
      tick();
      check("upwrap_0", int'(exp_count), 0);
      tick();
      check("upwrap_1", int'(exp_count), 1);

      // 4. injected fault at model value 56
      drive(0, 1, 1, 8'd50); tick();
      drive(0, 0, 1, 8'd0);
      repeat (6) tick();
      check("pre_fault_exp", int'(exp_count), 56);
      force_en = 1'b1; force_val = 8'd57;
      tick();
      force_en = 1'b0;
      check("fault_err", int'(err), 1);
      check("fault_err_cnt", int'(err_cnt), 1);
`ifdef CHK_ERR_CAPTURE_EN
      check("cap_valid_lit", int'(cap_valid), 1);
      check("cap_exp_lit", int'(cap_exp), 56);
      check("cap_act_lit", int'(cap_act), 57);
`endif
      tick();
      check("fault_single_pulse", int'(err), 0);

      // 5. unsynced mismatches, then rst+load together
      #2 rst = 1'b1; #2 rst = 1'b0;
      force_en = 1'b1; force_val = 8'd99;
      repeat (3) tick();
      check("unsync_no_err", int'(err), 0);
      check("unsync_synced", int'(synced), 0);
      force_en = 1'b0;
      drive(1, 1, 1, 8'd100); tick();
      check("rst_beats_load", int'(exp_count), 0);
      check("rst_load_synced", int'(synced), 1);

      // 6. stuck count: saturation, then mid-cycle rst
      drive(0, 0, 1, 8'd0);
      force_en = 1'b1; force_val = 8'd200;
      repeat (5) tick();
      check("sat_err_cnt", int'(err_cnt), 3);
      check("sat_err_pulsing", int'(err), 1);
      #2 rst = 1'b1;
      #1;
      check("midrst_err_cnt", int'(err_cnt), 0);
      check("midrst_synced", int'(synced), 0);
      check("midrst_err", int'(err), 0);
      tick();
      rst = 1'b0;
      force_en = 1'b0;
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/up_down_count_checker.md
# up_down_count_checker

Synthesizable observer for the 8-bit up/down counter. It samples the counter's control inputs and its `count` output, keeps a reference model of the count, and flags every cycle where the two disagree. It sits next to the counter in simulation and FPGA debug builds, on the monitoring side of the counter interface. It never drives the counter.

## Interface
- `WIDTH`, 8: count and data width.
- `ERR_CNT_W`, 8: width of the mismatch counter.
- `clk` in 1: clock, the same clock as the monitored counter.
- `rst` in 1: asynchronous, active-high checker reset. It is independent of `mon_rst`.
- `mon_rst` in 1: the counter's reset input (synchronous to `clk` at the counter).
- `mon_load` in 1: the counter's load strobe.
- `mon_updown` in 1: the counter's direction; 1 counts up, 0 counts down.
- `mon_data_in` in WIDTH: the counter's load value.
- `mon_count` in WIDTH: the counter's output.
- `synced` out 1: high while the reference model is valid.
- `err` out 1: one-cycle pulse for each mismatch.
- `err_cnt` out ERR_CNT_W: number of mismatches, saturating.
- `exp_count` out WIDTH: current model value.

## Operation
- Reference counter semantics, applied at each posedge in priority order:
  - `mon_rst`=1 gives 0.
  - Otherwise `mon_load`=1 gives `mon_data_in`.
  - Otherwise `mon_updown`=1 gives +1, else -1.
  - Arithmetic is modulo 2^WIDTH, so 255+1 gives 0 and 0-1 gives 255.
- The FSM has two states, UNSYNC and CHECK.
- UNSYNC:
  - No comparison is made and `err` stays 0.
  - A sampled `mon_rst`=1 or `mon_load`=1 loads the model per the semantics above and moves to CHECK.
- CHECK, at every posedge, in this order:
  - Compare the sampled `mon_count` with the model value held since the previous edge. On mismatch, assert `err` and increment `err_cnt`.
  - Update the model from the sampled controls.
- On a mismatch the model is not resynchronised to `mon_count`. A stuck counter therefore produces continuing errors.
- `mon_rst` and `mon_load` asserted together: reset wins and the model becomes 0.
- `err_cnt` saturates at 2^ERR_CNT_W-1. Further mismatches still pulse `err`.
- `synced` is 1 exactly when the state is CHECK.
- `exp_count` shows the model register.

## Timing
- Reset (`rst`=1, asynchronous) sets:
  - state UNSYNC, `synced`=0, `err`=0;
  - `err_cnt`=0, `exp_count`=0;
  - capture registers 0 and `cap_valid`=0.
- All outputs are registered.
- `err` is high in the cycle after the edge at which the mismatching `mon_count` was sampled.
- `err_cnt` updates on that same edge.
- Model latency: the controls sampled at edge k set `exp_count` after edge k. `mon_count` is compared with it at edge k+1.
- `rst` asserted mid-operation:
  - returns the FSM to UNSYNC immediately;
  - clears counters;
  - any pending `err` pulse is dropped.
- A `mon_rst` pulse while in CHECK realigns the model to 0 and stays in CHECK.

## Configuration
- `CHK_ERR_CAPTURE_EN`, defined:
  - Adds outputs `cap_valid` (1), `cap_exp` (WIDTH) and `cap_act` (WIDTH).
  - The first mismatch after `rst` latches the expected and actual values and sets `cap_valid`.
  - Later mismatches do not overwrite the capture until the next `rst`.
- `CHK_ERR_CAPTURE_EN` undefined: those ports and registers are absent. Everything else is identical.

## Structure
- Shared package `updown_chk_pkg`:
  - FSM state typedef (`ST_UNSYNC`, `ST_CHECK`);
  - default `WIDTH` and `ERR_CNT_W` constants.
- One natural sub-module, `updown_ref_model`: the model register plus next-value logic. It takes the `mon_*` controls and an enable, and outputs the model value.
- The top level holds the FSM, comparator, error counter and capture logic.

## Test plan
1. Reset and sync:
   - Apply `rst`, then `mon_rst` for 1 cycle, with `mon_count` following a correct counter → `synced`=1 one cycle after the `mon_rst` edge.
   - Then `mon_updown`=1 for 10 cycles → `exp_count` reaches 10, `err` never asserts.
2. Load and down-wrap:
   - `mon_load`=1, `mon_data_in`=200 → `exp_count`=200.
   - Then load 0 and count down → `exp_count` shows 255, 254, …, no `err`.
3. Up-wrap:
   - Load 254, up 3 cycles → `exp_count` shows 255, 0, 1, no `err`.
4. Injected fault:
   - Force `mon_count`=57 when the model is 56 → single `err` pulse on the next cycle and `err_cnt`=1.
   - With `CHK_ERR_CAPTURE_EN` defined: `cap_exp`=56, `cap_act`=57, `cap_valid`=1.
5. Simultaneous and unsynced events:
   - Mismatches sampled in UNSYNC → no `err`.
   - `mon_rst` and `mon_load` (data 100) asserted together → `exp_count`=0.
6. Saturation and mid-run reset:
   - With `ERR_CNT_W`=2, hold `mon_count` stuck → `err_cnt` stops at 3 while `err` keeps pulsing.
   - Then assert `rst` mid-cycle → `err_cnt`=0 and `synced`=0 immediately.
